serial_sub4: RTL and testbench

SERIAL_SUB4 -- requirements
Module: serial_sub4

---
 rtl/serial_sub4_if.sv | 23 ++
 rtl/serial_sub4.sv | 72 +++++++
 tb/tb_serial_sub4.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/serial_sub4_if.sv
// Operand/result bundle for the bit-serial 4-bit subtractor.
// The master side issues Start and operands; the slave side returns the result and status.
interface serial_sub4_if;
    logic       Start;
    logic       borrowin;
    logic [3:0] X;
    logic [3:0] Y;
    logic [3:0] D;
    logic       borrowout;
    logic       Overflow;
    logic       Busy;
    logic       Done;

    modport master (
        output Start, borrowin, X, Y,
        input  D, borrowout, Overflow, Busy, Done
    );

    modport slave (
        input  Start, borrowin, X, Y,
        output D, borrowout, Overflow, Busy, Done
    );
endinterface

// File: rtl/serial_sub4.sv
// Bit-serial 4-bit subtractor: a single full-subtractor cell walks the operands LSB first.
// One capture edge plus four shift edges per result; outputs only change on the last shift edge.
module serial_sub4 (
    input  logic         Clock,
    input  logic         Resetn,
    serial_sub4_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     state;
    logic [1:0] cnt;
    logic [3:0] xr, yr, res;
    logic       br;
    logic [3:0] d_q;
    logic       bo_q, ov_q;

    logic       xb, yb, dbit, bnext;
    logic [3:0] dnew;

    assign xb    = xr[cnt];
    assign yb    = yr[cnt];
    assign dbit  = xb ^ yb ^ br;
    assign bnext = (~xb & yb) | (~(xb ^ yb) & br);
    // Difference bits enter at the MSB so bit 0 ends up at res[0] after four shifts.
    assign dnew  = {dbit, res[3:1]};

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
            cnt   <= 2'd0;
            xr    <= 4'd0;
            yr    <= 4'd0;
            br    <= 1'b0;
            res   <= 4'd0;
            d_q   <= 4'd0;
            bo_q  <= 1'b0;
            ov_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.Start) begin
                        xr    <= bus.X;
                        yr    <= bus.Y;
                        br    <= bus.borrowin;
                        cnt   <= 2'd0;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    res <= dnew;
                    br  <= bnext;
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        d_q   <= dnew;
                        bo_q  <= bnext;
                        ov_q  <= (xr[3] != yr[3]) && (dbit != xr[3]);
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.D         = d_q;
    assign bus.borrowout = bo_q;
    assign bus.Overflow  = ov_q;
    assign bus.Busy      = (state == SHIFT);
    assign bus.Done      = (state == DONE);
endmodule

// File: tb/tb_serial_sub4.sv
// Bench for serial_sub4: fixed vectors, start-during-shift, reset abort, back-to-back
// streaming, an exhaustive operand sweep and random operations against an arithmetic model.
module tb_serial_sub4;
    logic Clock;
    logic Resetn;
    int   checks;
    int   errors;

    serial_sub4_if bus();

    serial_sub4 dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic       b;
        logic [3:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned borrow from sign of the difference,
    // overflow from the signed result leaving the 4-bit range.
    function automatic void model(input logic [3:0] x, input logic [3:0] y, input logic b,
                                  output logic [3:0] d, output logic bo, output logic ov);
        int ud, sd;
        ud = int'(x) - int'(y) - int'(b);
        sd = int'($signed(x)) - int'($signed(y)) - int'(b);
        d  = ud[3:0];
        bo = (ud < 0);
        ov = (sd < -8) || (sd > 7);
    endfunction

    task automatic op(input logic [3:0] x, input logic [3:0] y, input logic b, input bit poke,
                      output logic [3:0] rd, output logic rbo, output logic rov);
        logic [3:0] d0, md;
        logic       bo0, ov0, mbo, mov;
        int         nb, nd, nchg;
        model(x, y, b, md, mbo, mov);
        @(negedge Clock);
        bus.X = x; bus.Y = y; bus.borrowin = b; bus.Start = 1'b1;
        d0 = bus.D; bo0 = bus.borrowout; ov0 = bus.Overflow;
        @(negedge Clock);
        nb = 0; nd = 0; nchg = 0;
        for (int i = 0; i < 4; i++) begin
            nb += int'(bus.Busy);
            nd += int'(bus.Done);
            if ({bus.D, bus.borrowout, bus.Overflow} !== {d0, bo0, ov0}) nchg++;
            if (poke) begin
                bus.Start = 1'b1; bus.X = 4'hf; bus.Y = 4'h0; bus.borrowin = 1'b0;
            end else begin
                bus.Start = 1'($urandom); bus.X = 4'($urandom);
                bus.Y = 4'($urandom); bus.borrowin = 1'($urandom);
            end
            @(negedge Clock);
        end
        bus.Start = 1'b0;
        chk("busy_cycles", 32'(nb), 32'd4);
        chk("done_in_shift", 32'(nd), 32'd0);
        chk("hold_in_shift", 32'(nchg), 32'd0);
        chk("done_pulse", 32'(bus.Done), 32'd1);
        chk("busy_in_done", 32'(bus.Busy), 32'd0);
        chk("D_model", 32'(bus.D), 32'(md));
        chk("borrowout_model", 32'(bus.borrowout), 32'(mbo));
        chk("Overflow_model", 32'(bus.Overflow), 32'(mov));
        rd = bus.D; rbo = bus.borrowout; rov = bus.Overflow;
        @(negedge Clock);
        chk("done_drop", 32'(bus.Done), 32'd0);
        chk("no_restart", 32'(bus.Busy), 32'd0);
    endtask

    initial begin
        logic [3:0] rd;
        logic       rbo, rov;
        int         ndone, nz;
        int         dpos[$];

        checks = 0; errors = 0;
        tbl[0] = '{x:4'b0111, y:4'b0011, b:1'b0, d:4'b0100, bo:1'b0, ov:1'b0};
        tbl[1] = '{x:4'b0011, y:4'b0101, b:1'b0, d:4'b1110, bo:1'b1, ov:1'b0};
        tbl[2] = '{x:4'b1000, y:4'b0001, b:1'b0, d:4'b0111, bo:1'b0, ov:1'b1};
        tbl[3] = '{x:4'b0111, y:4'b1111, b:1'b0, d:4'b1000, bo:1'b1, ov:1'b1};
        tbl[4] = '{x:4'b0000, y:4'b0000, b:1'b1, d:4'b1111, bo:1'b1, ov:1'b0};
        tbl[5] = '{x:4'b0101, y:4'b0010, b:1'b0, d:4'b0011, bo:1'b0, ov:1'b0};

        bus.Start = 1'b0; bus.X = 4'd0; bus.Y = 4'd0; bus.borrowin = 1'b0;
        Resetn = 1'b0;
        #1;
        chk("rst_outputs", 32'({bus.D, bus.borrowout, bus.Overflow, bus.Busy, bus.Done}), 32'd0);
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;

        for (int i = 0; i < 6; i++) begin
            op(tbl[i].x, tbl[i].y, tbl[i].b, 1'b0, rd, rbo, rov);
            chk($sformatf("tbl%0d_D", i), 32'(rd), 32'(tbl[i].d));
            chk($sformatf("tbl%0d_bo", i), 32'(rbo), 32'(tbl[i].bo));
            chk($sformatf("tbl%0d_ov", i), 32'(rov), 32'(tbl[i].ov));
        end

        // Start held with new operands through SHIFT must not disturb 7-3.
        op(4'b0111, 4'b0011, 1'b0, 1'b1, rd, rbo, rov);
        chk("poke_D", 32'(rd), 32'h4);
        nz = 0;
        repeat (4) begin
            @(negedge Clock);
            nz += int'(bus.Done) + int'(bus.Busy);
        end
        chk("poke_no_second_op", 32'(nz), 32'd0);

        // Reset in the second SHIFT cycle abandons the operation.
        @(negedge Clock);
        bus.X = 4'b1001; bus.Y = 4'b0001; bus.borrowin = 1'b0; bus.Start = 1'b1;
        @(negedge Clock);
        bus.Start = 1'b0;
        @(negedge Clock);
        chk("pre_rst_busy", 32'(bus.Busy), 32'd1);
        Resetn = 1'b0;
        #1;
        chk("midop_rst_outputs", 32'({bus.D, bus.borrowout, bus.Overflow, bus.Busy, bus.Done}), 32'd0);
        @(negedge Clock);
        Resetn = 1'b1;
        nz = 0;
        repeat (8) begin
            @(negedge Clock);
            nz += int'(bus.Done) + int'(bus.Busy);
        end
        chk("rst_no_done", 32'(nz), 32'd0);
        op(4'b0101, 4'b0010, 1'b0, 1'b0, rd, rbo, rov);
        chk("post_rst_D", 32'(rd), 32'h3);

        // Start held high: one Done every 5 cycles.
        @(negedge Clock);
        bus.X = 4'b0111; bus.Y = 4'b0011; bus.borrowin = 1'b0; bus.Start = 1'b1;
        ndone = 0;
        for (int c = 0; c < 22; c++) begin
            @(negedge Clock);
            if (bus.Done === 1'b1) begin
                dpos.push_back(c);
                chk("b2b_D", 32'(bus.D), 32'h4);
                ndone++;
            end
        end
        bus.Start = 1'b0;
        chk("b2b_count", 32'(ndone), 32'd4);
        for (int j = 0; j < dpos.size(); j++)
            chk($sformatf("b2b_pos%0d", j), 32'(dpos[j]), 32'(4 + 5 * j));
        repeat (8) @(negedge Clock);
        chk("b2b_idle", 32'({bus.Busy, bus.Done}), 32'd0);

        for (int v = 0; v < 512; v++) begin
            logic [8:0] vv;
            vv = 9'(v);
            op(vv[8:5], vv[4:1], vv[0], 1'b0, rd, rbo, rov);
        end

        for (int r = 0; r < 40; r++)
            op(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), rd, rbo, rov);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
